// File: rtl/music_ctrl_pkg.sv
// Shared types and constants for the music controller.
package music_ctrl_pkg;

  // FSM state encodings; the raw values are visible on the state output.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPlay  = 2'd1,
    StPause = 2'd2,
    StOver  = 2'd3
  } state_e;

  // Saturation limit for the per-game cleared-line total.
  localparam int unsigned LINES_MAX = 999;

  // A single drop can never credit more than this many lines.
  localparam logic [2:0] LINES_CLAMP = 3'd4;

  // Width of the OVER dwell timer.
  localparam int unsigned DWELL_W = 27;

  // Limit a raw lines_cleared value to the legal maximum.
  function automatic logic [2:0] clamp_lines(input logic [2:0] n);
    return (n > LINES_CLAMP) ? LINES_CLAMP : n;
  endfunction

endpackage

// File: rtl/music_ctrl_line_counter.sv
// Line bookkeeping: clamps each drop, tracks the in-level count, speed
// and the saturating game total, and flags every speed increment.
module music_ctrl_line_counter #(
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned MAX_SPEED       = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       lines_valid,
  input  logic [2:0] lines_cleared,
  output logic [3:0] speed,
  output logic [9:0] total_lines,
  output logic       level_up
);
  import music_ctrl_pkg::*;

  localparam logic [4:0]  LplW     = 5'(LINES_PER_LEVEL);
  localparam logic [3:0]  MaxSpdW  = 4'(MAX_SPEED);
  localparam logic [10:0] LinesMax = 11'(LINES_MAX);

  logic [3:0]  count_q;
  logic [3:0]  speed_q;
  logic [9:0]  total_q;
  logic        level_up_q;

  logic [2:0]  n;
  logic [4:0]  sum;
  logic [10:0] tot_sum;

  // Clamp the drop size and form the candidate in-level and total sums.
  always_comb begin
    n       = clamp_lines(lines_cleared);
    sum     = {1'b0, count_q} + {2'b00, n};
    tot_sum = {1'b0, total_q} + {8'h00, n};
  end

  // Counter state; clear restarts the game, zero-line drops change nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= 4'd0;
      speed_q    <= 4'd1;
      total_q    <= 10'd0;
      level_up_q <= 1'b0;
    end else begin
      level_up_q <= 1'b0;
      if (clear) begin
        count_q <= 4'd0;
        speed_q <= 4'd1;
        total_q <= 10'd0;
      end else if (lines_valid && (n != 3'd0)) begin
        if (sum >= LplW) begin
          // Count keeps wrapping even once speed has topped out.
          count_q <= 4'(sum - LplW);
          if (speed_q < MaxSpdW) begin
            speed_q    <= speed_q + 4'd1;
            level_up_q <= 1'b1;
          end
        end else begin
          count_q <= sum[3:0];
        end
        total_q <= (tot_sum >= LinesMax) ? LinesMax[9:0] : tot_sum[9:0];
      end
    end
  end

  assign speed       = speed_q;
  assign total_lines = total_q;
  assign level_up    = level_up_q;

endmodule

// File: rtl/music_ctrl.sv
// Game-state FSM driving the background-music player: arbitrates the
// control pulses, runs the OVER dwell timer and gates the music enable.
module music_ctrl #(
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned MAX_SPEED       = 9,
  parameter int unsigned OVER_CYCLES     = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_start,
  input  logic       game_over,
  input  logic       pause_tgl,
  input  logic       mute,
  input  logic       lines_valid,
  input  logic [2:0] lines_cleared,
  output logic       music_en,
  output logic [3:0] speed,
  output logic [9:0] total_lines,
  output logic       level_up,
  output logic [1:0] state
);
  import music_ctrl_pkg::*;

  // Loaded on OVER entry so the exit lands exactly OVER_CYCLES edges later.
  localparam logic [DWELL_W-1:0] DwellLoad = DWELL_W'(OVER_CYCLES - 1);

  logic [1:0]         rst_sync_q;
  logic               rst_int;
  state_e             state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               music_en_q;

  logic in_game;
  logic over_acc;
  logic start_acc;
  logic pause_acc;
  logic lines_acc;

  // Reset asserts immediately, releases two clk edges after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int = rst_sync_q[1];

  // Accept only events legal in the current state, highest priority wins.
  always_comb begin
    in_game   = (state_q == StPlay) || (state_q == StPause);
    over_acc  = game_over && in_game;
    start_acc = game_start && !over_acc;
    pause_acc = pause_tgl && in_game && !over_acc && !start_acc;
    lines_acc = lines_valid && (state_q == StPlay) && !over_acc && !start_acc && !pause_acc;
  end

  // Next state and dwell timer; the timer only moves while in OVER.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    if (over_acc) begin
      state_d = StOver;
      dwell_d = DwellLoad;
    end else if (start_acc) begin
      state_d = StPlay;
      dwell_d = '0;
    end else begin
      case (state_q)
        StPlay: begin
          if (pause_acc) state_d = StPlay == StPlay ? StPause : StPlay;
        end
        StPause: begin
          if (pause_acc) state_d = StPlay;
        end
        StOver: begin
          if (dwell_q == '0) begin
            state_d = StIdle;
          end else begin
            dwell_d = dwell_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM registers with the registered music enable.
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      state_q    <= StIdle;
      dwell_q    <= '0;
      music_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      music_en_q <= (state_d == StPlay) && !mute;
    end
  end

  music_ctrl_line_counter #(
    .LINES_PER_LEVEL (LINES_PER_LEVEL),
    .MAX_SPEED       (MAX_SPEED)
  ) u_line_counter (
    .clk           (clk),
    .rst           (rst_int),
    .clear         (start_acc),
    .lines_valid   (lines_acc),
    .lines_cleared (lines_cleared),
    .speed         (speed),
    .total_lines   (total_lines),
    .level_up      (level_up)
  );

  assign music_en = music_en_q;
  assign state    = state_q;

endmodule

// File: tb/tb_music_ctrl.sv
// Directed bench for music_ctrl with a short OVER dwell.
module tb_music_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       game_start;
  logic       game_over;
  logic       pause_tgl;
  logic       mute;
  logic       lines_valid;
  logic [2:0] lines_cleared;
  logic       music_en;
  logic [3:0] speed;
  logic [9:0] total_lines;
  logic       level_up;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  music_ctrl #(
    .LINES_PER_LEVEL (10),
    .MAX_SPEED       (9),
    .OVER_CYCLES     (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .game_start    (game_start),
    .game_over     (game_over),
    .pause_tgl     (pause_tgl),
    .mute          (mute),
    .lines_valid   (lines_valid),
    .lines_cleared (lines_cleared),
    .music_en      (music_en),
    .speed         (speed),
    .total_lines   (total_lines),
    .level_up      (level_up),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle event pulse, then back to idle inputs.
  task automatic ev(input logic go, input logic gs, input logic pt, input logic lv,
                    input logic [2:0] n);
    game_over     = go;
    game_start    = gs;
    pause_tgl     = pt;
    lines_valid   = lv;
    lines_cleared = n;
    tick();
    game_over     = 1'b0;
    game_start    = 1'b0;
    pause_tgl     = 1'b0;
    lines_valid   = 1'b0;
    lines_cleared = 3'd0;
  endtask

  initial begin
    rst = 1'b0; game_start = 0; game_over = 0; pause_tgl = 0; mute = 0;
    lines_valid = 0; lines_cleared = 3'd0;
    tick(); tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_music_en", 32'(music_en), 32'd0);
    check("rst_speed", 32'(speed), 32'd1);
    check("rst_total", 32'(total_lines), 32'd0);
    check("rst_level_up", 32'(level_up), 32'd0);

    rst = 1'b1;
    tick(); tick(); tick();
    check("idle_after_release", 32'(state), 32'd0);

    // Start game
    ev(0, 1, 0, 0, 3'd0);
    check("start_state", 32'(state), 32'd1);
    check("start_music_en", 32'(music_en), 32'd1);
    check("start_speed", 32'(speed), 32'd1);
    check("start_total", 32'(total_lines), 32'd0);

    // 4, 4, 3 -> first level up
    ev(0, 0, 0, 1, 3'd4);
    ev(0, 0, 0, 1, 3'd4);
    check("lu_before", 32'(level_up), 32'd0);
    check("total_8", 32'(total_lines), 32'd8);
    ev(0, 0, 0, 1, 3'd3);
    check("lvl_speed2", 32'(speed), 32'd2);
    check("lvl_level_up", 32'(level_up), 32'd1);
    check("lvl_count1", 32'(dut.u_line_counter.count_q), 32'd1);
    check("lvl_total11", 32'(total_lines), 32'd11);
    tick();
    check("lvl_level_up_drop", 32'(level_up), 32'd0);

    // 17 x 4 lines: 69 in-level lines -> speed 8, count 9
    for (int i = 0; i < 17; i++) ev(0, 0, 0, 1, 3'd4);
    check("speed8", 32'(speed), 32'd8);
    check("total79", 32'(total_lines), 32'd79);
    ev(0, 0, 0, 1, 3'd1);
    check("speed9", 32'(speed), 32'd9);
    check("speed9_level_up", 32'(level_up), 32'd1);
    check("speed9_count0", 32'(dut.u_line_counter.count_q), 32'd0);
    check("total80", 32'(total_lines), 32'd80);

    // 20 more lines at max speed, raw 7 clamped to 4
    for (int i = 0; i < 5; i++) begin
      ev(0, 0, 0, 1, 3'd7);
      check("max_no_level_up", 32'(level_up), 32'd0);
    end
    check("max_speed_hold", 32'(speed), 32'd9);
    check("max_total100", 32'(total_lines), 32'd100);
    check("max_count_wrap", 32'(dut.u_line_counter.count_q), 32'd0);
    ev(0, 0, 0, 1, 3'd0);
    check("zero_lines_noop", 32'(total_lines), 32'd100);

    // Pause beats lines in the same cycle
    ev(0, 0, 1, 1, 3'd2);
    check("pause_state", 32'(state), 32'd2);
    check("pause_music_en", 32'(music_en), 32'd0);
    check("pause_total", 32'(total_lines), 32'd100);
    ev(0, 0, 0, 1, 3'd3);
    check("pause_lines_ignored", 32'(total_lines), 32'd100);
    ev(0, 0, 1, 0, 3'd0);
    check("resume_state", 32'(state), 32'd1);
    check("resume_music_en", 32'(music_en), 32'd1);

    // Mute
    mute = 1'b1;
    tick();
    check("mute_music_en", 32'(music_en), 32'd0);
    check("mute_state", 32'(state), 32'd1);
    mute = 1'b0;
    tick();
    check("unmute_music_en", 32'(music_en), 32'd1);

    // game_over wins over game_start; dwell of 8
    ev(1, 1, 0, 0, 3'd0);
    check("over_state", 32'(state), 32'd3);
    check("over_music_en", 32'(music_en), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("over_hold_total", 32'(total_lines), 32'd100);
    check("over_hold_speed", 32'(speed), 32'd9);
    tick();
    check("over_still_at_7", 32'(state), 32'd3);
    tick();
    check("idle_at_8", 32'(state), 32'd0);

    // New game, drive total to saturation
    ev(0, 1, 0, 0, 3'd0);
    check("restart_total0", 32'(total_lines), 32'd0);
    check("restart_speed1", 32'(speed), 32'd1);
    for (int i = 0; i < 250; i++) ev(0, 0, 0, 1, 3'd4);
    check("sat_total999", 32'(total_lines), 32'd999);
    check("sat_speed9", 32'(speed), 32'd9);

    // Restart from PLAY clears counters
    ev(0, 1, 0, 0, 3'd0);
    check("replay_state", 32'(state), 32'd1);
    check("replay_total0", 32'(total_lines), 32'd0);
    check("replay_speed1", 32'(speed), 32'd1);
    ev(0, 0, 0, 1, 3'd4);
    check("replay_total4", 32'(total_lines), 32'd4);

    // Asynchronous reset mid-game
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_total", 32'(total_lines), 32'd0);
    check("async_rst_speed", 32'(speed), 32'd1);
    check("async_rst_music_en", 32'(music_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/music_ctrl.md
MUSIC_CTRL -- requirements
Module: music_ctrl

Interface
REQ-001 Parameter LINES_PER_LEVEL, default 10: cleared lines per speed step; legal range 4..15.
REQ-002 Parameter MAX_SPEED, default 9: highest speed value driven to the note player.
REQ-003 Parameter OVER_CYCLES, default 100000000: OVER-state dwell in clk cycles (2 s at 50 MHz).
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 game_start  input  1  one-cycle pulse, new game requested.
REQ-007 game_over  input  1  one-cycle pulse, stack reached top.
REQ-008 pause_tgl  input  1  one-cycle pulse, toggle pause.
REQ-009 mute  input  1  level, silences music while high.
REQ-010 lines_valid  input  1  one-cycle pulse, lines_cleared valid.
REQ-011 lines_cleared  input  3  lines removed by one drop.
REQ-012 music_en  output  1  enable to note player; low restarts the melody.
REQ-013 speed  output  4  note-player tempo select, 1..MAX_SPEED.
REQ-014 total_lines  output  10  lines cleared this game, saturating at 999.
REQ-015 level_up  output  1  one-cycle pulse on every speed increment.
REQ-016 state  output  2  current FSM state encoding.

Function
REQ-017 FSM states: IDLE, PLAY, PAUSE, OVER.
REQ-018 IDLE --game_start--> PLAY; game_start also clears total_lines and the in-level count and sets speed to 1.
REQ-019 PLAY --pause_tgl--> PAUSE; PAUSE --pause_tgl--> PLAY.
REQ-020 PLAY or PAUSE --game_over--> OVER; OVER returns to IDLE after exactly OVER_CYCLES cycles.
REQ-021 game_start in PLAY, PAUSE or OVER restarts the game: clears counters, sets speed 1, enters PLAY.
REQ-022 Same-cycle event priority: game_over > game_start > pause_tgl > lines_valid; lower-priority events that cycle are dropped.
REQ-023 Events not valid in the current state are ignored, with no side effect.
REQ-024 lines_valid is accepted only in PLAY; lines_cleared 0 is a no-op; values 5..7 are clamped to 4.
REQ-025 In-level count update: sum = count + n. If sum >= LINES_PER_LEVEL, count <= sum - LINES_PER_LEVEL and speed increments; otherwise count <= sum.
REQ-026 At most one speed step per event.
REQ-027 At speed == MAX_SPEED, speed holds, level_up stays low, and the in-level count keeps wrapping.
REQ-028 total_lines adds n and saturates at 999.
REQ-029 All outputs are registered; each takes effect on the clock edge after the causing input pulse (latency 1).
REQ-030 music_en = (state == PLAY) and not mute, registered.
REQ-031 In PAUSE and OVER, speed and total_lines hold their values.
REQ-032 Counters and speed are cleared only by game_start or reset.
REQ-033 The OVER dwell counter is 27 bits, reloads on OVER entry, and is idle in all other states.

Reset
REQ-034 rst low: state IDLE, music_en 0, speed 1, total_lines 0, in-level count 0, level_up 0, dwell counter 0.
REQ-035 Reset assertion acts immediately and asynchronously; deassertion is synchronised to clk by the top level.
REQ-036 Reset mid-game discards all progress; there is no resume.

Structure
REQ-037 The shared package holds the state encodings (IDLE=0, PLAY=1, PAUSE=2, OVER=3), the LINES_MAX=999 constant and the lines_cleared clamp value 4.
REQ-038 Sub-module line_counter holds the clamp, the in-level count, speed and total_lines, and outputs level_up; the FSM and dwell timer stay in music_ctrl.

Verification
REQ-039 Reset release, then game_start -> next cycle: state PLAY, music_en 1, speed 1, total_lines 0.
REQ-040 In PLAY: lines 4, 4, 3 -> after the third pulse: speed 2, level_up high one cycle, in-level count 1, total_lines 11.
REQ-041 Drive speed to 9, then clear 20 more lines -> speed stays 9, no level_up, total_lines keeps increasing.
REQ-042 pause_tgl and lines_valid(2) in the same cycle from PLAY -> PAUSE, music_en 0, total_lines unchanged; second pause_tgl -> PLAY, music_en 1.
REQ-043 game_over with game_start in the same cycle -> OVER; with OVER_CYCLES=8 -> IDLE exactly 8 cycles later.
REQ-044 mute high in PLAY -> music_en 0 next cycle, state still PLAY; rst pulsed low mid-game -> all outputs at reset values immediately.
